// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave front-end for a dual-port block RAM: byte-lane writes, registered
// reads with single-cycle read-after-write forwarding, and a two-cycle ERROR response.
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_WADDR,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_RADDR,
    input  logic [31:0]           BRAM_RDATA
);

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    lane_mask = 4'b0001 << a;
            3'd1:    lane_mask = 4'b0011 << a;
            default: lane_mask = 4'hF;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] size, input logic [1:0] a);
        case (size)
            3'd0:    is_illegal = 1'b0;
            3'd1:    is_illegal = a[0];
            3'd2:    is_illegal = (a != 2'b00);
            default: is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [3:0] m, input logic [31:0] fwd,
                                                input logic [31:0] ram);
        for (int n = 0; n < 4; n++)
            merge_bytes[8*n +: 8] = m[n] ? fwd[8*n +: 8] : ram[8*n +: 8];
    endfunction

    state_t                  state_q, state_d;
    logic                    accept, illegal, acc_ok, acc_err;
    logic [ADDR_WIDTH-1:0]   haddr_idx;

    logic                    vld_p0;
    logic                    wr_p0;
    logic [3:0]              mask_p0;
    logic [ADDR_WIDTH-1:0]   idx_p0;

    logic                    vld_p1;
    logic [3:0]              fwd_mask_p1;
    logic [31:0]             fwd_data_p1;
    logic [ADDR_WIDTH-1:0]   fwd_idx_p1;

    logic                    rd_phase, fwd_hit;
    logic                    unused_ok;

    assign unused_ok = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    assign haddr_idx = HADDR[ADDR_WIDTH+1:2];
    // ERR1 holds HREADYOUT low, so no new address phase can complete there.
    assign accept    = HSEL & HREADY & HTRANS[1] & (state_q != ST_ERR1);
    assign illegal   = is_illegal(HSIZE, HADDR[1:0]);
    assign acc_ok    = accept & ~illegal;
    assign acc_err   = accept & illegal;

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            ST_OKAY: if (acc_err) state_d = ST_ERR1;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = 1'b1;
                state_d = acc_err ? ST_ERR1 : ST_OKAY;
            end
            default: state_d = ST_OKAY;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state_q <= ST_OKAY;
        else          state_q <= state_d;
    end

    // Stage p0: address phase latched, data phase follows
    always_ff @(posedge HCLK) begin
        if (!HRESETn) vld_p0 <= 1'b0;
        else          vld_p0 <= acc_ok;
    end

    always_ff @(posedge HCLK) begin
        if (acc_ok) begin
            wr_p0   <= HWRITE;
            mask_p0 <= lane_mask(HSIZE, HADDR[1:0]);
            idx_p0  <= haddr_idx;
        end
    end

    // Gating with HRESETn keeps the RAM from committing a write whose data phase is reset.
    assign BRAM_WE    = (vld_p0 && wr_p0 && HRESETn) ? mask_p0 : 4'h0;
    assign BRAM_WADDR = idx_p0;
    assign BRAM_WDATA = HWDATA;
    assign BRAM_RADDR = haddr_idx;

    // Stage p1: last write cycle, kept for one cycle of forwarding
    always_ff @(posedge HCLK) begin
        if (!HRESETn) vld_p1 <= 1'b0;
        else          vld_p1 <= (BRAM_WE != 4'h0);
    end

    always_ff @(posedge HCLK) begin
        if (BRAM_WE != 4'h0) begin
            fwd_mask_p1 <= BRAM_WE;
            fwd_data_p1 <= HWDATA;
            fwd_idx_p1  <= idx_p0;
        end
    end

    assign rd_phase = vld_p0 & ~wr_p0;
    assign fwd_hit  = rd_phase & vld_p1 & (fwd_idx_p1 == idx_p0);
    assign HRDATA   = fwd_hit ? merge_bytes(fwd_mask_p1, fwd_data_p1, BRAM_RDATA) : BRAM_RDATA;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed bench for ahb_bram_ctrl: per-cycle expectations are queued by the stimulus
// and consumed by an independent monitor on the falling clock edge.
module tb_ahb_bram_ctrl;

    localparam int AW = 14;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] ID = 2'b00;

    logic          HCLK = 1'b0;
    logic          HRESETn, HSEL, HWRITE, HREADY;
    logic [31:0]   HADDR, HWDATA;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HREADYOUT, HRESP;
    logic [31:0]   HRDATA, BRAM_WDATA, BRAM_RDATA;
    logic [3:0]    BRAM_WE;
    logic [AW-1:0] BRAM_WADDR, BRAM_RADDR;

    logic [31:0]   mem [0:(1<<AW)-1];

    typedef struct {
        logic        rdy;
        logic        resp;
        logic [3:0]  we;
        logic [13:0] waddr;
        logic [31:0] wdata;
        logic        chkrd;
        logic [31:0] rd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .BRAM_WADDR(BRAM_WADDR), .BRAM_WDATA(BRAM_WDATA), .BRAM_WE(BRAM_WE),
        .BRAM_RADDR(BRAM_RADDR), .BRAM_RDATA(BRAM_RDATA)
    );

    always #5 HCLK = ~HCLK;

    // Block RAM: byte-lane write, registered read returning old data on collision.
    always @(posedge HCLK) begin
        for (int n = 0; n < 4; n++)
            if (BRAM_WE[n]) mem[BRAM_WADDR][8*n +: 8] <= BRAM_WDATA[8*n +: 8];
        BRAM_RDATA <= mem[BRAM_RADDR];
    end

    always @(negedge HCLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (HREADYOUT !== e.rdy) begin
                errors++;
                $display("FAIL hreadyout t=%0t got %b want %b", $time, HREADYOUT, e.rdy);
            end
            checks++;
            if (HRESP !== e.resp) begin
                errors++;
                $display("FAIL hresp t=%0t got %b want %b", $time, HRESP, e.resp);
            end
            checks++;
            if (BRAM_WE !== e.we) begin
                errors++;
                $display("FAIL bram_we t=%0t got %h want %h", $time, BRAM_WE, e.we);
            end
            if (e.we != 4'h0) begin
                checks++;
                if (BRAM_WADDR !== e.waddr || BRAM_WDATA !== e.wdata) begin
                    errors++;
                    $display("FAIL bram_wr t=%0t got %h/%h want %h/%h", $time,
                             BRAM_WADDR, BRAM_WDATA, e.waddr, e.wdata);
                end
            end
            if (e.chkrd) begin
                checks++;
                if (HRDATA !== e.rd) begin
                    errors++;
                    $display("FAIL hrdata t=%0t got %h want %h", $time, HRDATA, e.rd);
                end
            end
        end
    end

    task automatic cyc(input logic rstn, input logic sel, input logic hrdy,
                       input logic [1:0] tr, input logic [2:0] sz, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic erdy, input logic eresp, input logic [3:0] ewe,
                       input logic [13:0] ewaddr, input logic chkrd, input logic [31:0] erd);
        exp_t e;
        HRESETn = rstn; HSEL = sel; HREADY = hrdy; HTRANS = tr; HSIZE = sz;
        HWRITE = wr; HADDR = addr; HWDATA = wdata;
        e.rdy = erdy; e.resp = eresp; e.we = ewe; e.waddr = ewaddr; e.wdata = wdata;
        e.chkrd = chkrd; e.rd = erd;
        q.push_back(e);
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input logic [31:0] wdata, input logic erdy, input logic eresp,
                        input logic [3:0] ewe, input logic [13:0] ewaddr,
                        input logic chkrd, input logic [31:0] erd);
        cyc(1'b1, 1'b0, 1'b1, ID, 3'd2, 1'b0, 32'h0, wdata, erdy, eresp, ewe, ewaddr, chkrd, erd);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        HRESETn = 1'b0; HSEL = 1'b0; HREADY = 1'b1; HTRANS = ID; HSIZE = 3'd2;
        HWRITE = 1'b0; HADDR = 32'h0; HWDATA = 32'h0;
        repeat (2) @(posedge HCLK);
        #1;
        cyc(1'b0, 1'b0, 1'b1, ID, 3'd2, 1'b0, 32'h0, 32'h0, 1, 0, 4'h0, 0, 0, 0);

        // Word write then separated read
        cyc(1, 1, 1, NS, 3'd2, 1, 32'h10, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'hDEADBEEF, 1, 0, 4'hF, 14'd4, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, NS, 3'd2, 0, 32'h10, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 1, 32'hDEADBEEF);

        // Byte write into an existing word
        cyc(1, 1, 1, NS, 3'd2, 1, 32'h10, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h11223344, 1, 0, 4'hF, 14'd4, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, NS, 3'd0, 1, 32'h13, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'hAB000000, 1, 0, 4'b1000, 14'd4, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, NS, 3'd2, 0, 32'h10, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 1, 32'hAB223344);

        // Half write immediately followed by read of the same word (forwarding)
        cyc(1, 1, 1, NS, 3'd2, 1, 32'h20, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h12345678, 1, 0, 4'hF, 14'd8, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, NS, 3'd1, 1, 32'h22, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, NS, 3'd2, 0, 32'h20, 32'hBEEF0000, 1, 0, 4'b1100, 14'd8, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 1, 32'hBEEF5678);

        // Misaligned half: ERR1, then read accepted during ERR2
        cyc(1, 1, 1, NS, 3'd1, 1, 32'h01, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'hFFFFFFFF, 0, 1, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, NS, 3'd2, 0, 32'h10, 32'h0, 1, 1, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 1, 32'hAB223344);

        // Misaligned word and oversize transfer never write
        cyc(1, 1, 1, NS, 3'd2, 1, 32'h12, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'hFFFFFFFF, 0, 1, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 1, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, NS, 3'd3, 1, 32'h10, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'hFFFFFFFF, 0, 1, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 1, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, NS, 3'd2, 0, 32'h10, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 1, 32'hAB223344);

        // Transfers that must not be accepted
        cyc(1, 1, 0, NS, 3'd2, 1, 32'h10, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, ID, 3'd2, 1, 32'h10, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(1, 0, 1, NS, 3'd2, 1, 32'h10, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, NS, 3'd2, 0, 32'h10, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 1, 32'hAB223344);

        // Out-of-range address wraps onto word 4
        cyc(1, 1, 1, NS, 3'd2, 1, 32'h10010, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'hCAFEF00D, 1, 0, 4'hF, 14'd4, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, NS, 3'd2, 0, 32'h10, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 1, 32'hCAFEF00D);

        // Reset during a write data phase drops the write
        cyc(1, 1, 1, NS, 3'd2, 1, 32'h40, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(0, 0, 1, ID, 3'd2, 0, 32'h0, 32'h55555555, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, NS, 3'd2, 0, 32'h40, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 1, 32'h0);

        // Reset during ERR1 aborts the error response
        cyc(1, 1, 1, NS, 3'd1, 1, 32'h43, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(0, 0, 1, ID, 3'd2, 0, 32'h0, 32'hFFFFFFFF, 0, 1, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 0, 0);
        cyc(1, 1, 1, NS, 3'd2, 0, 32'h40, 32'h0, 1, 0, 4'h0, 0, 0, 0);
        idle(32'h0, 1, 0, 4'h0, 0, 1, 32'h0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge HCLK);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
